traffic_light_monitor: RTL and testbench

- Passive checker on the six light lines driven by the traffic controller: the receiving end of the light interface.
- Samples the lines every clock and decodes them into a phase.
- Checks for conflicts, illegal patterns, illegal phase order and wrong dwell times, and counts completed rotations.
- Sits beside the controller in system and test builds; drives sticky error flags to status/interrupt logic.

---
 rtl/traffic_light_monitor.sv | 164 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive monitor for the six traffic-light lines: decodes the phase, checks pattern,
// order and dwell, counts FY->HWG rotations and raises sticky error flags.
module traffic_light_monitor #(
  parameter int GREEN_CYCLES  = 50,
  parameter int YELLOW_CYCLES = 10,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hw_green,
  input  logic                 hw_yellow,
  input  logic                 hw_red,
  input  logic                 farm_green,
  input  logic                 farm_yellow,
  input  logic                 farm_red,
  input  logic                 clr_err,
  output logic [1:0]           phase,
  output logic                 phase_valid,
  output logic                 err_conflict,
  output logic                 err_pattern,
  output logic                 err_sequence,
  output logic                 err_timing,
  output logic                 err_any,
  output logic [CNT_WIDTH-1:0] last_dwell,
  output logic [CNT_WIDTH-1:0] rot_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIRST = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [1:0] PH_HWG = 2'd0;
  localparam logic [1:0] PH_HWY = 2'd1;
  localparam logic [1:0] PH_FG  = 2'd2;
  localparam logic [1:0] PH_FY  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] GREEN_DWELL  = CNT_WIDTH'(GREEN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] YELLOW_DWELL = CNT_WIDTH'(YELLOW_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DWELL_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = {CNT_WIDTH{1'b0}};

  logic [1:0]           r_state;
  logic [1:0]           r_phase;
  logic                 r_phase_valid;
  logic                 r_err_conflict;
  logic                 r_err_pattern;
  logic                 r_err_sequence;
  logic                 r_err_timing;
  logic                 r_err_any;
  logic [CNT_WIDTH-1:0] r_dwell;
  logic [CNT_WIDTH-1:0] r_last_dwell;
  logic [CNT_WIDTH-1:0] r_rot_count;

  logic [5:0]           w_lights;
  logic                 w_legal;
  logic [1:0]           w_dec;
  logic                 w_non_red_both;
  logic                 w_ev_conflict;
  logic                 w_ev_pattern;
  logic                 w_change;
  logic                 w_ev_sequence;
  logic                 w_ev_timing;
  logic                 w_rot;
  logic [CNT_WIDTH-1:0] w_expected;
  logic                 w_nx_conflict;
  logic                 w_nx_pattern;
  logic                 w_nx_sequence;
  logic                 w_nx_timing;

  assign w_lights = {hw_green, hw_yellow, hw_red, farm_green, farm_yellow, farm_red};

  // Decode the four legal light patterns into a phase.
  always_comb begin
    w_legal = 1'b0;
    w_dec   = PH_HWG;
    case (w_lights)
      6'b100_001: begin w_legal = 1'b1; w_dec = PH_HWG; end
      6'b010_001: begin w_legal = 1'b1; w_dec = PH_HWY; end
      6'b001_100: begin w_legal = 1'b1; w_dec = PH_FG;  end
      6'b001_010: begin w_legal = 1'b1; w_dec = PH_FY;  end
      default:    begin w_legal = 1'b0; w_dec = PH_HWG; end
    endcase
  end

  assign w_non_red_both = (hw_green | hw_yellow) & (farm_green | farm_yellow);
  assign w_ev_conflict  = ~w_legal & w_non_red_both;
  assign w_ev_pattern   = ~w_legal & ~w_non_red_both;

  // Even phases are green, odd phases are yellow.
  assign w_expected    = r_phase[0] ? YELLOW_DWELL : GREEN_DWELL;
  assign w_change      = w_legal & (r_state != ST_IDLE) & (w_dec != r_phase);
  assign w_ev_sequence = w_change & (w_dec != (r_phase + 2'd1));
  assign w_ev_timing   = w_change & (r_state == ST_TRACK) & (r_dwell != w_expected);
  assign w_rot         = w_change & (r_phase == PH_FY) & (w_dec == PH_HWG);

  // A new event wins over a simultaneous clear.
  assign w_nx_conflict = (r_err_conflict & ~clr_err) | w_ev_conflict;
  assign w_nx_pattern  = (r_err_pattern  & ~clr_err) | w_ev_pattern;
  assign w_nx_sequence = (r_err_sequence & ~clr_err) | w_ev_sequence;
  assign w_nx_timing   = (r_err_timing   & ~clr_err) | w_ev_timing;

  // Monitor state, phase tracking, dwell counting and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_phase        <= PH_HWG;
      r_phase_valid  <= 1'b0;
      r_err_conflict <= 1'b0;
      r_err_pattern  <= 1'b0;
      r_err_sequence <= 1'b0;
      r_err_timing   <= 1'b0;
      r_err_any      <= 1'b0;
      r_dwell        <= CNT_ZERO;
      r_last_dwell   <= CNT_ZERO;
      r_rot_count    <= CNT_ZERO;
    end else begin
      r_err_conflict <= w_nx_conflict;
      r_err_pattern  <= w_nx_pattern;
      r_err_sequence <= w_nx_sequence;
      r_err_timing   <= w_nx_timing;
      r_err_any      <= w_nx_conflict | w_nx_pattern | w_nx_sequence | w_nx_timing;
      if (!w_legal) begin
        r_phase_valid <= 1'b0;
        r_state       <= ST_IDLE;
        r_dwell       <= CNT_ZERO;
      end else if (r_state == ST_IDLE) begin
        r_phase_valid <= 1'b1;
        r_phase       <= w_dec;
        r_dwell       <= CNT_ONE;
        r_state       <= ST_FIRST;
      end else if (w_change) begin
        r_phase_valid <= 1'b1;
        r_phase       <= w_dec;
        r_last_dwell  <= r_dwell;
        r_dwell       <= CNT_ONE;
        r_state       <= ST_TRACK;
        if (w_rot) begin
          r_rot_count <= r_rot_count + CNT_ONE;
        end else begin
          r_rot_count <= r_rot_count;
        end
      end else begin
        r_phase_valid <= 1'b1;
        if (r_dwell != DWELL_MAX) begin
          r_dwell <= r_dwell + CNT_ONE;
        end else begin
          r_dwell <= r_dwell;
        end
      end
    end
  end

  assign phase        = r_phase;
  assign phase_valid  = r_phase_valid;
  assign err_conflict = r_err_conflict;
  assign err_pattern  = r_err_pattern;
  assign err_sequence = r_err_sequence;
  assign err_timing   = r_err_timing;
  assign err_any      = r_err_any;
  assign last_dwell   = r_last_dwell;
  assign rot_count    = r_rot_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized controller-like
// traffic, checked every cycle against a behavioural model of the light rules.
module tb_traffic_light_monitor;

  localparam int G   = 5;
  localparam int Y   = 2;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          hw_green, hw_yellow, hw_red;
  logic          farm_green, farm_yellow, farm_red;
  logic          clr_err;
  logic [1:0]    phase;
  logic          phase_valid;
  logic          err_conflict, err_pattern, err_sequence, err_timing, err_any;
  logic [CW-1:0] last_dwell;
  logic [CW-1:0] rot_count;

  traffic_light_monitor #(.GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .hw_green(hw_green), .hw_yellow(hw_yellow), .hw_red(hw_red),
    .farm_green(farm_green), .farm_yellow(farm_yellow), .farm_red(farm_red),
    .clr_err(clr_err),
    .phase(phase), .phase_valid(phase_valid),
    .err_conflict(err_conflict), .err_pattern(err_pattern),
    .err_sequence(err_sequence), .err_timing(err_timing), .err_any(err_any),
    .last_dwell(last_dwell), .rot_count(rot_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model state: outputs plus whether a baseline exists and whether dwell is trustworthy
  int m_phase, m_valid, m_conf, m_pat, m_seq, m_tim, m_any, m_last, m_rot;
  int run_len;
  bit synced, timed;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] lights_of(input int ph);
    case (ph)
      0:       return 6'b100_001;
      1:       return 6'b010_001;
      2:       return 6'b001_100;
      default: return 6'b001_010;
    endcase
  endfunction

  task automatic model_step(input logic [5:0] l, input logic clr, input logic rst);
    int hw_on, fm_on, ph;
    bit legal, conflict, ev_c, ev_p, ev_s, ev_t;
    if (!rst) begin
      m_phase = 0; m_valid = 0; m_conf = 0; m_pat = 0; m_seq = 0; m_tim = 0;
      m_any = 0; m_last = 0; m_rot = 0; run_len = 0; synced = 0; timed = 0;
      return;
    end
    hw_on    = int'(l[5]) + int'(l[4]) + int'(l[3]);
    fm_on    = int'(l[2]) + int'(l[1]) + int'(l[0]);
    legal    = (hw_on == 1) && (fm_on == 1) && (l[3] != l[0]);
    conflict = (l[5] || l[4]) && (l[2] || l[1]);
    ph       = l[3] ? (l[2] ? 2 : 3) : (l[5] ? 0 : 1);
    ev_c = 0; ev_p = 0; ev_s = 0; ev_t = 0;
    if (!legal) begin
      if (conflict) ev_c = 1; else ev_p = 1;
      m_valid = 0;
      synced  = 0;
    end else if (!synced) begin
      synced = 1; timed = 0; m_phase = ph; run_len = 1; m_valid = 1;
    end else if (ph == m_phase) begin
      run_len = (run_len < MAX) ? run_len + 1 : MAX;
      m_valid = 1;
    end else begin
      if (ph != (m_phase + 1) % 4) ev_s = 1;
      if (timed && run_len != ((m_phase % 2 == 0) ? G : Y)) ev_t = 1;
      if (m_phase == 3 && ph == 0) m_rot = (m_rot + 1) % (MAX + 1);
      m_last = run_len; run_len = 1; m_phase = ph; timed = 1; m_valid = 1;
    end
    m_conf = int'((m_conf != 0 && !clr) || ev_c);
    m_pat  = int'((m_pat  != 0 && !clr) || ev_p);
    m_seq  = int'((m_seq  != 0 && !clr) || ev_s);
    m_tim  = int'((m_tim  != 0 && !clr) || ev_t);
    m_any  = int'(m_conf != 0 || m_pat != 0 || m_seq != 0 || m_tim != 0);
  endtask

  task automatic compare_all();
    chk("phase",        32'(phase),        32'(m_phase));
    chk("phase_valid",  32'(phase_valid),  32'(m_valid));
    chk("err_conflict", 32'(err_conflict), 32'(m_conf));
    chk("err_pattern",  32'(err_pattern),  32'(m_pat));
    chk("err_sequence", 32'(err_sequence), 32'(m_seq));
    chk("err_timing",   32'(err_timing),   32'(m_tim));
    chk("err_any",      32'(err_any),      32'(m_any));
    chk("last_dwell",   32'(last_dwell),   32'(m_last));
    chk("rot_count",    32'(rot_count),    32'(m_rot));
  endtask

  task automatic tick(input logic [5:0] l, input logic clr, input logic rst);
    {hw_green, hw_yellow, hw_red, farm_green, farm_yellow, farm_red} = l;
    clr_err = clr;
    rst_n   = rst;
    model_step(l, clr, rst);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input int ph, input int n);
    for (int k = 0; k < n; k++) tick(lights_of(ph), 1'b0, 1'b1);
  endtask

  int ph_r, left, nom;
  logic [5:0] l_r;
  logic c_r, r_r;

  initial begin
    {hw_green, hw_yellow, hw_red, farm_green, farm_yellow, farm_red} = 6'b000_000;
    clr_err = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    tick(6'b100_001, 1'b0, 1'b0);
    tick(6'b100_001, 1'b0, 1'b0);
    chk("lit_reset_valid", 32'(phase_valid), 32'd0);
    chk("lit_reset_rot",   32'(rot_count),   32'd0);

    // three clean rotations, then the closing HWG sample
    for (int r = 0; r < 3; r++) begin
      hold(0, G); hold(1, Y); hold(2, G); hold(3, Y);
    end
    hold(0, 1);
    chk("lit_rot3",       32'(rot_count),  32'd3);
    chk("lit_last_fy",    32'(last_dwell), 32'd2);
    chk("lit_clean_any",  32'(err_any),    32'd0);

    // HWG held 6 cycles in total
    hold(0, 5); hold(1, 1);
    chk("lit_long_timing", 32'(err_timing), 32'd1);
    chk("lit_long_last",   32'(last_dwell), 32'd6);
    chk("lit_long_any",    32'(err_any),    32'd1);

    tick(lights_of(1), 1'b1, 1'b1);
    chk("lit_clr_any", 32'(err_any), 32'd0);

    // HWG straight to FG with correct dwell
    hold(2, G); hold(3, Y); hold(0, G); hold(2, 1);
    chk("lit_skip_seq", 32'(err_sequence), 32'd1);
    chk("lit_skip_tim", 32'(err_timing),   32'd0);
    chk("lit_skip_rot", 32'(rot_count),    32'd4);

    tick(lights_of(2), 1'b1, 1'b1);
    tick(6'b100_100, 1'b0, 1'b1);
    chk("lit_conf_flag",  32'(err_conflict), 32'd1);
    chk("lit_conf_valid", 32'(phase_valid),  32'd0);
    chk("lit_conf_pat",   32'(err_pattern),  32'd0);
    hold(1, 1);
    chk("lit_resync_valid", 32'(phase_valid), 32'd1);
    hold(2, 1);
    chk("lit_resync_seq", 32'(err_sequence), 32'd0);
    chk("lit_resync_tim", 32'(err_timing),   32'd0);

    tick(6'b001_001, 1'b1, 1'b1);
    chk("lit_clr_vs_pat", 32'(err_pattern),  32'd1);
    chk("lit_clr_conf",   32'(err_conflict), 32'd0);

    // reset in the middle of FG, then a truncated first phase
    hold(0, 1); hold(1, Y); hold(2, 2);
    tick(lights_of(2), 1'b0, 1'b0);
    chk("lit_mid_rst_any", 32'(err_any),   32'd0);
    chk("lit_mid_rst_rot", 32'(rot_count), 32'd0);
    hold(2, 2); hold(3, Y); hold(0, 1);
    chk("lit_trunc_tim", 32'(err_timing), 32'd0);
    chk("lit_trunc_rot", 32'(rot_count),  32'd1);

    // saturated dwell always mismatches
    hold(0, 19); hold(1, 1);
    chk("lit_sat_last", 32'(last_dwell), 32'(MAX));
    chk("lit_sat_tim",  32'(err_timing), 32'd1);

    // randomized controller-like traffic with faults, clears and resets
    ph_r = 1; left = Y;
    for (int i = 0; i < 4000; i++) begin
      r_r = ($urandom_range(0, 499) != 0);
      c_r = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) begin
        l_r = 6'($urandom);
      end else begin
        if (left <= 0) begin
          ph_r = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : (ph_r + 1) % 4;
          nom  = (ph_r % 2 == 0) ? G : Y;
          if ($urandom_range(0, 39) == 0)      left = int'($urandom_range(14, 20));
          else if ($urandom_range(0, 7) == 0)  left = nom + int'($urandom_range(0, 2)) - 1;
          else                                 left = nom;
          if (left < 1) left = 1;
        end
        l_r = lights_of(ph_r);
        left--;
      end
      tick(l_r, c_r, r_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
